seven_seg_scanner: RTL and testbench

Time-multiplexed display controller that shares one BCD-to-segment decoder (`sevenSegments`) between NUM_DIGITS common-anode digits. It accepts a packed BCD value through a valid/ready load handshake and holds it in a pending register. The value moves into the display register only at frame boundaries, so the display never tears. The block scans the digits with a programmable slot time, inserts anti-ghosting guard time, and optionally blanks leading zeros. Segment and anode outputs are active-low.

---
 rtl/seven_seg_scanner_pkg.sv | 14 +
 rtl/seven_seg_scanner_seven_segments.sv | 25 ++
 rtl/seven_seg_scanner.sv | 138 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: digit width,
// dark segment pattern and the per-cycle scan phase.
package seven_seg_scanner_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_GUARD,
    ST_DRIVE
  } scan_state_e;

endpackage

// File: rtl/seven_seg_scanner_seven_segments.sv
// Combinational BCD to active-low {a,b,c,d,e,f,g} decoder; codes A-F show "0".
module sevenSegments
  import seven_seg_scanner_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       dec
);

  always_comb begin
    case (bcd)
      4'd0:    dec = 7'b0000001;
      4'd1:    dec = 7'b1001111;
      4'd2:    dec = 7'b0010010;
      4'd3:    dec = 7'b0000110;
      4'd4:    dec = 7'b1001100;
      4'd5:    dec = 7'b0100100;
      4'd6:    dec = 7'b0100000;
      4'd7:    dec = 7'b0001111;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0000100;
      default: dec = 7'b0000001;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display driver with frame-aligned value
// updates, per-slot guard time and optional leading-zero blanking.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 16,
  parameter bit LZB_EN     = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] value,
  output logic                        ready,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic [6:0]                  seg_n,
  output logic [2:0]                  digit_idx,
  output logic                        frame_tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DRIVE = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] digits_t;

  digits_t               pend_q, disp_q;
  logic                  pend_valid_q;
  logic                  accept, transfer;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  scan_state_e           state;
  logic [NUM_DIGITS-1:0] blank;
  logic                  upper_nz;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] an_n_d, an_n_q;
  logic [6:0]            seg_n_d, seg_n_q;
  logic [2:0]            idx_out_d, idx_out_q;
  logic                  tick_d, tick_q;

  // Pending can only be refilled once it has drained, so accept and transfer
  // never coincide; the displayed value changes only during a guard phase.
  assign accept   = load && !pend_valid_q;
  assign transfer = pend_valid_q && (tick_q || !enable);

  // NOTE: the value registers are small and must come up blank, so they are
  // reset like any other state rather than left to power-up contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      disp_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (accept) begin
        pend_q       <= value;
        pend_valid_q <= 1'b1;
      end else if (transfer) begin
        disp_q       <= pend_q;
        pend_valid_q <= 1'b0;
      end
    end
  end

  // A digit is blank when it and every digit above it are zero.
  always_comb begin
    blank    = '0;
    upper_nz = 1'b0;
    // NOTE: upper_nz is a running OR, so blocking = is required inside the loop.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_nz = upper_nz | (disp_q[i] != '0);
      blank[i] = LZB_EN && !upper_nz;
    end
  end

  sevenSegments u_dec (
    .bcd (disp_q[idx_q]),
    .dec (dec_seg)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state     = ST_OFF;
    cnt_d     = '0;
    idx_d     = '0;
    an_n_d    = '1;
    seg_n_d   = SEG_OFF;
    idx_out_d = '0;
    tick_d    = 1'b0;
    if (enable) begin
      state = (cnt_q < CNT_DRIVE) ? ST_GUARD : ST_DRIVE;
    end
    if (state != ST_OFF) begin
      idx_out_d = 3'(idx_q);
      tick_d    = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
      if (cnt_q == CNT_LAST) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
      end
    end
    if (state == ST_DRIVE && !blank[idx_q]) begin
      an_n_d[idx_q] = 1'b0;
      seg_n_d       = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      an_n_q    <= '1;
      seg_n_q   <= SEG_OFF;
      idx_out_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      an_n_q    <= an_n_d;
      seg_n_q   <= seg_n_d;
      idx_out_q <= idx_out_d;
      tick_q    <= tick_d;
    end
  end

  assign ready      = !pend_valid_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign digit_idx  = idx_out_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed and random checks of the scanner against a frame-position model,
// with blanking enabled and disabled side by side.
module tb_seven_seg_scanner;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * DIV;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;

  logic        ready, ready_b;
  logic [3:0]  an_n, an_n_b;
  logic [6:0]  seg_n, seg_n_b;
  logic [2:0]  digit_idx, digit_idx_b;
  logic        frame_tick, frame_tick_b;

  int          errors = 0;
  int          checks = 0;
  int          pos = 0;
  logic        exp_ready = 1'b1;
  logic [15:0] cur;
  logic [15:0] rv;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK_CYC(BLK), .LZB_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .ready      (ready),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  seven_seg_scanner #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK_CYC(BLK), .LZB_EN(1'b0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .ready      (ready_b),
    .an_n       (an_n_b),
    .seg_n      (seg_n_b),
    .digit_idx  (digit_idx_b),
    .frame_tick (frame_tick_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d < 4'd10) ? SEG_TAB[d] : SEG_TAB[0];
  endfunction

  // Expected {an_n, seg_n, digit_idx, frame_tick} at frame position p.
  function automatic logic [14:0] model(input logic [15:0] v, input int p,
                                        input bit lzb, input bit en);
    int         slot, c;
    logic [3:0] an, d;
    logic [6:0] seg;
    logic [15:0] upper;
    if (!en) return {4'hF, 7'h7F, 3'd0, 1'b0};
    slot  = p / DIV;
    c     = p % DIV;
    upper = v >> (4 * slot);
    d     = upper[3:0];
    an    = 4'hF;
    seg   = 7'h7F;
    if (c >= BLK && !(lzb && slot > 0 && upper == 16'h0)) begin
      an  = ~(4'd1 << slot);
      seg = seg_of(d);
    end
    return {an, seg, 3'(slot), 1'(p == FRAME - 1)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_check(input logic [15:0] v, input int n);
    for (int j = 0; j < n; j++) begin
      step();
      check($sformatf("scan_lzb p=%0d", pos),
            {an_n, seg_n, digit_idx, frame_tick}, model(v, pos, 1'b1, enable));
      check($sformatf("scan_nolzb p=%0d", pos),
            {an_n_b, seg_n_b, digit_idx_b, frame_tick_b}, model(v, pos, 1'b0, enable));
      check($sformatf("ready p=%0d", pos), {ready, ready_b}, {2{exp_ready}});
      if (enable) pos = (pos + 1) % FRAME;
    end
  endtask

  // Load while dark: accepted on one edge, displayed on the next.
  task automatic load_off(input logic [15:0] v);
    enable = 1'b0;
    scan_check(cur, 1);
    load      = 1'b1;
    value     = v;
    exp_ready = 1'b0;
    scan_check(cur, 1);
    load      = 1'b0;
    exp_ready = 1'b1;
    cur       = v;
    scan_check(cur, 1);
    enable = 1'b1;
    pos    = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    value  = '0;
    cur    = '0;

    step();
    check("reset_an_n", an_n, 4'hF);
    check("reset_seg_n", seg_n, 7'h7F);
    check("reset_ready", ready, 1'b1);
    check("reset_tick", frame_tick, 1'b0);
    check("reset_idx", digit_idx, 3'd0);
    rst_n = 1'b1;

    // Basic scan of 1234 over two frames.
    load_off(16'h1234);
    scan_check(cur, 2 * FRAME);

    // Mid-frame load; second load while busy is dropped.
    scan_check(cur, 10);
    load      = 1'b1;
    value     = 16'h5678;
    exp_ready = 1'b0;
    scan_check(cur, 1);
    value = 16'h9999;
    scan_check(cur, 1);
    load = 1'b0;
    scan_check(cur, FRAME - 12);
    exp_ready = 1'b1;
    cur       = 16'h5678;
    scan_check(cur, FRAME);

    // Load in the frame_tick cycle waits a whole frame.
    load      = 1'b1;
    value     = 16'h4321;
    exp_ready = 1'b0;
    scan_check(cur, 1);
    load = 1'b0;
    scan_check(cur, FRAME - 1);
    exp_ready = 1'b1;
    cur       = 16'h4321;
    scan_check(cur, FRAME);

    // Enable dropped mid-slot 2, then restored.
    scan_check(cur, 2 * DIV + 3);
    enable = 1'b0;
    scan_check(cur, 3);
    enable = 1'b1;
    pos    = 0;
    scan_check(cur, FRAME);

    // Leading-zero blanking and invalid digit.
    load_off(16'h0070);
    scan_check(cur, FRAME);
    load_off(16'h0000);
    scan_check(cur, FRAME);
    load_off(16'h000A);
    scan_check(cur, FRAME);

    // Random values, including invalid codes and leading zeros.
    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < 4; d++) begin
        rv[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      end
      rv = rv >> (4 * $urandom_range(0, 3));
      load_off(rv);
      scan_check(cur, FRAME);
    end

    // Async reset mid-DRIVE with a load pending: both values are lost.
    scan_check(cur, 4);
    load      = 1'b1;
    value     = 16'h1111;
    exp_ready = 1'b0;
    scan_check(cur, 2);
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an_n", an_n, 4'hF);
    check("async_seg_n", seg_n, 7'h7F);
    check("async_ready", ready, 1'b1);
    check("async_tick", frame_tick, 1'b0);
    check("async_idx", digit_idx, 3'd0);
    #1;
    rst_n     = 1'b1;
    exp_ready = 1'b1;
    cur       = 16'h0000;
    pos       = 0;
    scan_check(cur, FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
